mem_m_stream_ctrl: RTL and testbench

//  Sequencer for the modulus word ROM (registered address + registered output, 2-clk read latency,

---
 rtl/mem_ctrl_pkg.sv | 20 ++
 rtl/mem_m_fifo.sv | 67 ++++++
 rtl/mem_m_stream_ctrl.sv | 149 ++++++++++++++
 tb/tb_mem_m_stream_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared constants and state encoding for the modulus ROM streaming path.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // ROM read latency: registered address + registered data
  localparam int ROM_LAT = 2;

  // Defaults shared with the ROM wrapper and the MonPro core
  localparam int MEM_WIDTH      = 32;
  localparam int MEM_ADDR_WIDTH = 7;
  localparam int MEM_NWORDS     = 128;
  localparam int MEM_FIFO_DEPTH = 4;

endpackage

// File: rtl/mem_m_fifo.sv
// Small synchronous FIFO holding {last, idx, word} entries between ROM and stream port.
module mem_m_fifo #(
  parameter  int DW    = 40,
  parameter  int DEPTH = 4,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic [DW-1:0] i_din,
  input  logic          i_pop,
  output logic [DW-1:0] o_dout,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  // Pointer advance with explicit wrap so non-power-of-two depths work
  function automatic logic [PW-1:0] nxt_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_dout  = r_mem[r_rd];

  // A pop in the same cycle frees the slot, so push on full is accepted then
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  // Pointers and occupancy; flush empties the buffer in one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= nxt_ptr(r_wr);
      if (w_pop)  r_rd <= nxt_ptr(r_rd);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage array; contents are don't-care while the entry is not occupied
  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr] <= i_din;
  end

endmodule

// File: rtl/mem_m_stream_ctrl.sv
// Walks the modulus ROM once per start and streams words in order over valid/ready.
// Reads are only issued when a FIFO slot is guaranteed for them, so backpressure
// never loses or reorders data.
module mem_m_stream_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int WIDTH      = MEM_WIDTH,
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int NWORDS     = MEM_NWORDS,
  parameter int FIFO_DEPTH = MEM_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [WIDTH-1:0]      rom_data,
  output logic [WIDTH-1:0]      m_word,
  output logic [ADDR_WIDTH-1:0] m_idx,
  output logic                  m_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int DW = WIDTH + ADDR_WIDTH + 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = CW + 1;

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR_WIDTH-1:0]              r_cnt;
  logic [ROM_LAT:1]                   r_vld_pipe;
  logic [ROM_LAT:1]                   r_last_pipe;
  logic [ROM_LAT:1][ADDR_WIDTH-1:0]   r_idx_pipe;

  logic                  w_start;
  logic                  w_issue;
  logic                  w_cnt_last;
  logic                  w_flush;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [CW-1:0]         w_count;
  logic [OW-1:0]         w_inflight;
  logic [OW-1:0]         w_occ;
  logic [DW-1:0]         w_din;
  logic [DW-1:0]         w_dout;
  logic                  w_head_last;
  logic [ADDR_WIDTH-1:0] w_head_idx;
  logic [WIDTH-1:0]      w_head_word;

  assign w_flush    = abort;
  assign w_start    = (r_state == S_IDLE) & start & ~abort;
  assign w_cnt_last = (r_cnt == ADDR_WIDTH'(NWORDS - 1));

  // Count reads still travelling through the ROM
  always_comb begin
    w_inflight = '0;
    for (int k = 1; k <= ROM_LAT; k++) w_inflight = w_inflight + OW'(r_vld_pipe[k]);
  end

  // Credit: every issued read already owns a FIFO slot when its data returns
  assign w_occ   = w_inflight + OW'(w_count);
  assign w_issue = (r_state == S_RUN) & ~abort & (w_occ < OW'(FIFO_DEPTH));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state: abort always returns to IDLE and beats start
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_RUN;
      S_RUN:   if (abort) w_state_nxt = S_IDLE;
               else if (w_issue && w_cnt_last) w_state_nxt = S_DRAIN;
      S_DRAIN: if (abort) w_state_nxt = S_IDLE;
               else if (w_pop && w_head_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Issue counter doubles as the ROM address; holds at the last index, no wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       r_cnt <= '0;
    else if (w_start)                r_cnt <= '0;
    else if (w_issue && !w_cnt_last) r_cnt <= r_cnt + ADDR_WIDTH'(1);
  end

  assign rom_addr = r_cnt;

  // Tag pipe mirrors the ROM latency; abort drops every outstanding tag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld_pipe  <= '0;
      r_idx_pipe  <= '0;
      r_last_pipe <= '0;
    end else begin
      r_vld_pipe[1]  <= w_issue;
      r_idx_pipe[1]  <= r_cnt;
      r_last_pipe[1] <= w_cnt_last;
      for (int k = 2; k <= ROM_LAT; k++) begin
        r_vld_pipe[k]  <= r_vld_pipe[k-1];
        r_idx_pipe[k]  <= r_idx_pipe[k-1];
        r_last_pipe[k] <= r_last_pipe[k-1];
      end
      if (w_flush) r_vld_pipe <= '0;
    end
  end

  assign w_push = r_vld_pipe[ROM_LAT] & ~w_flush;
  assign w_din  = {r_last_pipe[ROM_LAT], r_idx_pipe[ROM_LAT], rom_data};
  assign w_pop  = m_valid & m_ready;

  mem_m_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign {w_head_last, w_head_idx, w_head_word} = w_dout;

  // Stream port shows the FIFO head, zeroed while nothing is valid
  assign m_valid = ~w_empty;
  assign m_word  = m_valid ? w_head_word : '0;
  assign m_idx   = m_valid ? w_head_idx  : '0;
  assign m_last  = m_valid & w_head_last;

  assign busy = (r_state == S_RUN) | (r_state == S_DRAIN);
  assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_mem_m_stream_ctrl.sv
// Scoreboard bench: stimulus queues expected words, a negedge monitor checks the stream.
module tb_mem_m_stream_ctrl;

  localparam int W  = 32;
  localparam int AW = 7;
  localparam int NW = 128;

  typedef struct packed {
    logic [AW-1:0] idx;
    logic [W-1:0]  word;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, abort, m_ready;
  logic [AW-1:0] rom_addr, m_idx;
  logic [W-1:0]  rom_data, m_word;
  logic          m_last, m_valid, busy, done;

  logic          start1, m_ready1;
  logic [AW-1:0] rom_addr1, m_idx1;
  logic [W-1:0]  rom_data1, m_word1;
  logic          m_last1, m_valid1, busy1, done1;

  logic [AW-1:0] rom_aq, rom_aq1;

  // ROM models: registered address then registered data, M[i] = A5000000 + i
  always @(posedge clk) begin
    rom_aq    <= rom_addr;
    rom_data  <= 32'hA500_0000 + 32'(rom_aq);
    rom_aq1   <= rom_addr1;
    rom_data1 <= 32'hA500_0000 + 32'(rom_aq1);
  end

  mem_m_stream_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .m_word(m_word), .m_idx(m_idx), .m_last(m_last), .m_valid(m_valid),
    .m_ready(m_ready), .busy(busy), .done(done)
  );

  mem_m_stream_ctrl #(.NWORDS(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .abort(1'b0),
    .rom_addr(rom_addr1), .rom_data(rom_data1),
    .m_word(m_word1), .m_idx(m_idx1), .m_last(m_last1), .m_valid(m_valid1),
    .m_ready(m_ready1), .busy(busy1), .done(done1)
  );

  int   n_pass = 0;
  int   n_chk  = 0;
  int   ovf_cnt = 0;
  exp_t q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Monitor: compare every accepted word, stall stability and the done pulse
  exp_t        e;
  logic        r_hold = 1'b0;
  logic        r_exp_done = 1'b0;
  logic [39:0] h_data;
  always @(negedge clk) begin
    if (reset) begin
      r_hold     = 1'b0;
      r_exp_done = 1'b0;
    end else begin
      if (dut.w_push && dut.w_full && !dut.w_pop) ovf_cnt++;
      if (r_hold) begin
        chk("stall_valid_held", 64'(m_valid), 64'(1));
        chk("stall_data_held", 64'({m_idx, m_word, m_last}), 64'(h_data));
      end
      if (done || r_exp_done) chk("done_pulse", 64'(done), 64'(r_exp_done));
      r_exp_done = 1'b0;
      if (m_valid && m_ready) begin
        if (q.size() == 0) begin
          n_chk++;
          $display("FAIL extra_word: got idx %0d, none expected", m_idx);
        end else begin
          e = q.pop_front();
          chk("word_idx", 64'(m_idx), 64'(e.idx));
          chk("word_data", 64'(m_word), 64'(e.word));
          chk("word_last", 64'(m_last), 64'(e.last));
          r_exp_done = m_last;
        end
      end
      r_hold = m_valid && !m_ready;
      h_data = {m_idx, m_word, m_last};
    end
  end

  // Queue a full pass of expected words and pulse start (sampled at the next edge)
  task automatic do_start();
    for (int i = 0; i < NW; i++)
      q.push_back('{idx: AW'(i), word: 32'hA500_0000 + 32'(i), last: 1'(i == NW - 1)});
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Run until done (bounded); optional random ready and a stray start pulse
  task automatic run_pass(input int maxc, input bit rnd, input int pulse_at, output int cyc);
    cyc = 0;
    while (cyc < maxc) begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc == pulse_at);
      if (rnd) m_ready = 1'($urandom_range(0, 1));
      if (done) break;
    end
    start   = 1'b0;
    m_ready = 1'b1;
  endtask

  task automatic end_of_pass(input string nm);
    chk({nm, "_queue_empty"}, 64'(q.size()), 64'(0));
    @(posedge clk); #1;
    chk({nm, "_busy_after"}, 64'(busy), 64'(0));
    chk({nm, "_done_after"}, 64'(done), 64'(0));
  endtask

  int cyc;
  bit found;

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; m_ready = 1'b1;
    start1 = 1'b0; m_ready1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", 64'(m_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_rom_addr", 64'(rom_addr), 64'(0));
    chk("rst_m_word", 64'({m_word, m_idx, m_last}), 64'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: full-rate pass, first word after E+3, done 131 edges after E
    do_start();
    repeat (2) @(posedge clk);
    #1 chk("lat_not_yet", 64'(m_valid), 64'(0));
    @(posedge clk); #1;
    chk("lat_first_valid", 64'(m_valid), 64'(1));
    chk("lat_first_idx", 64'(m_idx), 64'(0));
    chk("lat_first_word", 64'(m_word), 64'h0000_0000_A500_0000);
    run_pass(400, 1'b0, 0, cyc);
    chk("done_latency", 64'(cyc + 3), 64'(131));
    end_of_pass("p1");

    // 2: random backpressure
    do_start();
    run_pass(3000, 1'b1, 0, cyc);
    chk("rand_done_seen", 64'(done), 64'(1));
    end_of_pass("p2");

    // 3: ready held low: exactly FIFO_DEPTH reads issued, then release
    m_ready = 1'b0;
    do_start();
    repeat (20) @(posedge clk);
    #1;
    chk("stall_issued", 64'(rom_addr), 64'(4));
    chk("stall_busy", 64'(busy), 64'(1));
    chk("stall_head_idx", 64'(m_idx), 64'(0));
    m_ready = 1'b1;
    run_pass(400, 1'b0, 0, cyc);
    chk("stall_done_seen", 64'(done), 64'(1));
    end_of_pass("p3");

    // 4: abort at word 40, then restart from index 0
    do_start();
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(posedge clk); #1;
      found = m_valid && (m_idx == AW'(40));
    end
    chk("abort_point_found", 64'(found), 64'(1));
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    q.delete();
    chk("abort_m_valid", 64'(m_valid), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    repeat (4) begin
      @(posedge clk); #1;
      chk("abort_discard", 64'({m_valid, done}), 64'(0));
    end
    do_start();
    run_pass(400, 1'b0, 0, cyc);
    chk("restart_latency", 64'(cyc), 64'(131));
    end_of_pass("p4");

    // 5: start while busy ignored; start+abort together ignored; NWORDS=1
    do_start();
    run_pass(400, 1'b0, 10, cyc);
    chk("busy_start_ignored", 64'(cyc), 64'(131));
    end_of_pass("p5");
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", 64'(busy), 64'(0));
    repeat (4) begin
      @(posedge clk); #1;
      chk("start_abort_quiet", 64'({m_valid, busy}), 64'(0));
    end
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("n1_not_yet", 64'(m_valid1), 64'(0));
    @(posedge clk); #1;
    chk("n1_word", 64'({m_valid1, m_last1, m_idx1, m_word1}), {23'd0, 1'b1, 1'b1, 7'd0, 32'hA500_0000});
    chk("n1_busy", 64'(busy1), 64'(1));
    @(posedge clk); #1;
    chk("n1_done", 64'({done1, m_valid1, busy1}), 64'(3'b100));
    @(posedge clk); #1;
    chk("n1_idle", 64'({done1, busy1}), 64'(0));

    // 6: asynchronous reset mid-run
    do_start();
    repeat (20) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("arst_m_valid", 64'(m_valid), 64'(0));
    chk("arst_busy_done", 64'({busy, done}), 64'(0));
    chk("arst_rom_addr", 64'(rom_addr), 64'(0));
    chk("arst_m_fields", 64'({m_word, m_idx, m_last}), 64'(0));
    q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    do_start();
    run_pass(400, 1'b0, 0, cyc);
    chk("post_reset_latency", 64'(cyc), 64'(131));
    end_of_pass("p6");

    chk("no_fifo_overflow", 64'(ovf_cnt), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
